way_read_mux: RTL and testbench
===============================

# way_read_mux

Registered way-select read multiplexer for the set-associative cache data path. It takes one cache line per way, selects a line with a one-hot way vector, and optionally extracts a single word at a line offset. The result is delivered on a valid/ready output through a two-entry skid buffer, so the block sits between the data-array read stage and the core/refill response path. It also flags and counts multi-hit and no-hit selects.

## Interface
- LINE_SIZE_BYTES, 64, bytes per cache line; power of two.
- WAYS, 4, associativity; must be ≥ 2.
- WORD_BYTES, 8, bytes per word in word mode; power of two, < LINE_SIZE_BYTES.
- Derived: LW = LINE_SIZE_BYTES*8; WW = WORD_BYTES*8; OW = $clog2(LINE_SIZE_BYTES/WORD_BYTES); IW = $clog2(WAYS).

- i_clk  in  1  single clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_data  in  [LW-1:0] x WAYS  unpacked array of candidate lines, one per way.
- i_sel  in  WAYS  way select, expected one-hot.
- i_offset  in  OW  word index within the line; used only in word mode.
- i_word_mode  in  1  1 = word output; 0 = full-line output.
- i_valid  in  1  input beat valid.
- o_ready  out  1  block can accept a beat.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accepts the output beat.
- o_data  out  LW  selected line, or the selected word in [WW-1:0] with the upper bits zero.
- o_way  out  IW  encoded index of the selected way.
- o_hit  out  1  at least one i_sel bit was set.
- o_multi_hit  out  1  more than one i_sel bit was set.
- o_err_count  out  16  saturating count of accepted beats with o_multi_hit=1.

## Operation
- Accept: an input beat transfers when i_valid & o_ready at the clock edge. An output beat transfers when o_valid & i_ready.
- Select: the lowest-index set bit of i_sel wins. o_way = that index.
- No-hit (i_sel=0): the beat is still produced, with o_hit=0, o_data=0, o_way=0 and o_multi_hit=0.
- Multi-hit (more than one bit set): the beat uses the lowest index, o_multi_hit=1, and o_err_count increments, saturating at 16'hFFFF.
- Word mode: o_data[WW-1:0] = selected line bits [i_offset*WW +: WW]; o_data[LW-1:WW] = 0. Line mode: o_data = selected line, unmodified.
- The result (data, way, hit, multi_hit) is computed combinationally from the inputs and captured at accept. The input vector is not held after accept.
- Buffer: an output register (OUT) plus a skid register (SKID).
  - States: EMPTY (OUT invalid), ONE (OUT valid, SKID empty), FULL (both valid).
  - o_valid = OUT valid.
  - o_ready = ~SKID valid, decoded from state with no combinational path from i_ready.
- Transitions:
  - EMPTY, accept → ONE.
  - ONE, accept with no drain → FULL; the new beat goes to SKID.
  - ONE, accept with drain → ONE; OUT is reloaded with the new beat.
  - ONE, drain with no accept → EMPTY.
  - FULL, drain → ONE; SKID moves to OUT.
  - FULL has no accept, since o_ready=0.
- Beat order is always preserved.

## Timing
- Latency: accept at edge N → o_valid=1 with the beat after edge N (one cycle).
- Throughput: one beat per cycle while i_ready=1.
- o_data, o_way, o_hit and o_multi_hit are stable while o_valid=1 and i_ready=0.
- Reset (i_rst_n=0, asynchronous):
  - State = EMPTY.
  - o_valid=0, o_ready=1 (combinational from the empty SKID).
  - o_data=0, o_way=0, o_hit=0, o_multi_hit=0, o_err_count=0.
- Input beats are ignored while reset is asserted.
- Reset asserted mid-transfer discards both buffered beats immediately, with no partial output.
- After reset deasserts, the first accept can occur on the first clock edge.
- o_err_count increments on the accept edge of a multi-hit beat, not when that beat is output.

## Test plan
- Line mode, WAYS=4: i_sel=4'b0100, i_data[2]=pattern A, i_ready=1 → o_valid the next cycle, o_data=A, o_way=2, o_hit=1, o_multi_hit=0.
- Word mode: i_sel=4'b0001, i_offset=3, i_data[0][255:192]=64'hDEAD_BEEF_0123_4567 → o_data[63:0] = that value, o_data[511:64]=0.
- Backpressure: i_ready=0 and 3 consecutive i_valid beats (B0, B1, B2) →
  - o_ready drops after 2 accepts.
  - B2 is held off.
  - Releasing i_ready yields B0, B1, B2 in order, with no loss or duplication.
- Multi-hit: i_sel=4'b1010 → o_way=1, o_multi_hit=1, o_err_count=1. Force the count to 16'hFFFF and send a further multi-hit → the count stays at 16'hFFFF.
- No-hit: i_sel=0 → beat delivered with o_hit=0, o_data=0; o_err_count unchanged.
- Reset with FULL buffer: pulse i_rst_n low between edges → o_valid=0 and o_ready=1 immediately; the next accepted beat is the first one output.

Source files
------------

// File: rtl/way_read_mux.sv
// Way-select read mux: picks one line per one-hot way vector, optionally a word,
// and delivers it through a two-entry skid buffer with multi-hit counting.
//
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset
//   i_data[WAYS]          candidate lines, one per way
//   i_sel                 way select (one-hot expected, lowest set bit wins)
//   i_offset, i_word_mode word index / word-vs-line output select
//   i_valid, o_ready      input handshake
//   o_valid, i_ready      output handshake
//   o_data, o_way         selected line/word and encoded way
//   o_hit, o_multi_hit    select status for the beat
//   o_err_count           saturating count of accepted multi-hit beats
module way_read_mux #(
    parameter int LINE_SIZE_BYTES = 64,
    parameter int WAYS            = 4,
    parameter int WORD_BYTES      = 8,
    localparam int LW = LINE_SIZE_BYTES * 8,
    localparam int WW = WORD_BYTES * 8,
    localparam int NW = LINE_SIZE_BYTES / WORD_BYTES,
    localparam int OW = $clog2(NW),
    localparam int IW = $clog2(WAYS)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [LW-1:0] i_data [WAYS],
    input  logic [WAYS-1:0] i_sel,
    input  logic [OW-1:0] i_offset,
    input  logic          i_word_mode,
    input  logic          i_valid,
    output logic          o_ready,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [LW-1:0] o_data,
    output logic [IW-1:0] o_way,
    output logic          o_hit,
    output logic          o_multi_hit,
    output logic [15:0]   o_err_count
);

    typedef struct packed {
        logic [LW-1:0] data;
        logic [IW-1:0] way;
        logic          hit;
        logic          multi;
    } beat_t;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_FULL
    } state_e;

    state_e        state_q, state_d;
    beat_t         out_q, out_d;
    beat_t         skid_q, skid_d;
    logic [15:0]   err_q, err_d;

    logic [LW-1:0] sel_line;
    logic [IW-1:0] sel_way;
    logic [WW-1:0] words [NW];
    beat_t         in_beat;
    logic          accept;
    logic          drain;

    // Scan high-to-low so the lowest set bit is the last (winning) write.
    always_comb begin
        sel_line = '0;
        sel_way  = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (i_sel[i]) begin
                sel_line = i_data[i];
                sel_way  = IW'(i);
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NW; k++) begin
            words[k] = sel_line[k*WW +: WW];
        end
    end

    always_comb begin
        in_beat.data  = i_word_mode ? LW'(words[i_offset])
                                    : sel_line;
        in_beat.way   = sel_way;
        in_beat.hit   = |i_sel;
        // Clearing the lowest set bit leaves something iff >1 bit set.
        in_beat.multi = |(i_sel & (i_sel - WAYS'(1)));
    end

    assign o_valid = (state_q != S_EMPTY);
    assign o_ready = (state_q != S_FULL);
    assign accept  = i_valid & o_ready;
    assign drain   = o_valid & i_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        unique case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    out_d   = in_beat;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (accept && drain) begin
                    out_d = in_beat;
                end else if (accept) begin
                    skid_d  = in_beat;
                    state_d = S_FULL;
                end else if (drain) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (drain) begin
                    out_d   = skid_q;
                    state_d = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // Counted at accept so the count never lags behind a stalled output.
    always_comb begin
        err_d = err_q;
        if (accept && in_beat.multi && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            err_q   <= err_d;
        end
    end

    assign o_data      = out_q.data;
    assign o_way       = out_q.way;
    assign o_hit       = out_q.hit;
    assign o_multi_hit = out_q.multi;
    assign o_err_count = err_q;

endmodule

// File: tb/tb_way_read_mux.sv
// Bench for way_read_mux: vector table plus scoreboard of expected output beats,
// with hand sequences for backpressure, counter saturation and mid-flight reset.
module tb_way_read_mux;

    localparam int LB   = 64;
    localparam int WAYS = 4;
    localparam int WB   = 8;
    localparam int LW   = LB * 8;
    localparam int WW   = WB * 8;
    localparam int NW   = LB / WB;
    localparam int OW   = $clog2(NW);
    localparam int IW   = $clog2(WAYS);

    typedef logic [WAYS-1:0][LW-1:0] lines_t;

    typedef struct packed {
        logic [LW-1:0] data;
        logic [IW-1:0] way;
        logic          hit;
        logic          multi;
    } beat_t;

    typedef struct {
        logic [WAYS-1:0] sel;
        logic [OW-1:0]   off;
        logic            wm;
        logic [IW-1:0]   way;
        logic            hit;
        logic            multi;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [LW-1:0]   data [WAYS];
    logic [WAYS-1:0] sel;
    logic [OW-1:0]   off;
    logic            wm;
    logic            vin;
    logic            rdy_out;
    logic            vout;
    logic            rdy_in;
    logic [LW-1:0]   odata;
    logic [IW-1:0]   oway;
    logic            ohit;
    logic            omulti;
    logic [15:0]     oerr;

    always #5 clk = ~clk;

    way_read_mux #(
        .LINE_SIZE_BYTES(LB),
        .WAYS(WAYS),
        .WORD_BYTES(WB)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_data(data),
        .i_sel(sel),
        .i_offset(off),
        .i_word_mode(wm),
        .i_valid(vin),
        .o_ready(rdy_out),
        .o_valid(vout),
        .i_ready(rdy_in),
        .o_data(odata),
        .o_way(oway),
        .o_hit(ohit),
        .o_multi_hit(omulti),
        .o_err_count(oerr)
    );

    beat_t       sb[$];
    int          checks = 0;
    int          fails = 0;
    int          pushes = 0;
    int          pops = 0;
    logic [15:0] exp_err = 16'd0;
    vec_t        tbl[9];

    task automatic chk(input string name,
                       input logic [LW-1:0] act,
                       input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] pat(input int w, input int s);
        logic [LW-1:0] p;
        for (int k = 0; k < NW; k++) begin
            p[k*WW +: WW] = {8'(8'hA0 + w), 8'(k), 16'(s), 32'hC0DE_F00D};
        end
        return p;
    endfunction

    function automatic lines_t mk_lines(input int s);
        lines_t l;
        for (int w = 0; w < WAYS; w++) l[w] = pat(w, s);
        return l;
    endfunction

    function automatic beat_t mk_exp(input lines_t l,
                                     input logic [IW-1:0] way,
                                     input logic hit,
                                     input logic multi,
                                     input logic wmode,
                                     input logic [OW-1:0] o);
        beat_t b;
        b.way   = hit ? way : '0;
        b.hit   = hit;
        b.multi = multi;
        if (!hit) b.data = '0;
        else if (wmode) b.data = LW'(l[way][int'(o)*WW +: WW]);
        else b.data = l[way];
        return b;
    endfunction

    // Drives one beat from the falling edge and returns on its accept edge.
    task automatic send(input lines_t l,
                        input logic [WAYS-1:0] s,
                        input logic [OW-1:0] o,
                        input logic wmode,
                        input beat_t exp);
        bit done = 0;
        @(negedge clk);
        for (int w = 0; w < WAYS; w++) data[w] = l[w];
        sel = s;
        off = o;
        wm  = wmode;
        vin = 1'b1;
        for (int c = 0; c < 32 && !done; c++) begin
            #1;
            if (rdy_out) begin
                @(posedge clk);
                sb.push_back(exp);
                pushes++;
                if (exp.multi && exp_err != 16'hFFFF) exp_err++;
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            checks++;
            fails++;
            $display("FAIL send_timeout: got o_ready=0 want accept");
        end
    endtask

    task automatic idle();
        @(negedge clk);
        vin = 1'b0;
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 40 && sb.size() != 0; c++) @(negedge clk);
        #2;
        chk("drain_empty", LW'(sb.size()), '0);
    endtask

    always @(negedge clk) begin
        beat_t e;
        #1;
        if (rst_n && vout && rdy_in) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL extra_beat: got beat %0h want none", odata);
            end else begin
                e = sb.pop_front();
                pops++;
                chk("out_data", odata, e.data);
                chk("out_way", LW'(oway), LW'(e.way));
                chk("out_hit", LW'(ohit), LW'(e.hit));
                chk("out_multi", LW'(omulti), LW'(e.multi));
            end
        end
    end

    initial begin
        lines_t l;
        beat_t  b0, b1, b2, e;

        tbl[0] = '{4'b0100, 3'd0, 1'b0, 2'd2, 1'b1, 1'b0};
        tbl[1] = '{4'b0001, 3'd3, 1'b1, 2'd0, 1'b1, 1'b0};
        tbl[2] = '{4'b1000, 3'd0, 1'b0, 2'd3, 1'b1, 1'b0};
        tbl[3] = '{4'b0010, 3'd7, 1'b1, 2'd1, 1'b1, 1'b0};
        tbl[4] = '{4'b1010, 3'd0, 1'b0, 2'd1, 1'b1, 1'b1};
        tbl[5] = '{4'b0000, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[6] = '{4'b0000, 3'd5, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[7] = '{4'b1111, 3'd0, 1'b1, 2'd0, 1'b1, 1'b1};
        tbl[8] = '{4'b1100, 3'd2, 1'b1, 2'd2, 1'b1, 1'b1};

        vin    = 1'b0;
        sel    = '0;
        off    = '0;
        wm     = 1'b0;
        rdy_in = 1'b1;
        for (int w = 0; w < WAYS; w++) data[w] = '0;

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", LW'(vout), '0);
        chk("rst_ready", LW'(rdy_out), LW'(1));
        chk("rst_data", odata, '0);
        chk("rst_way", LW'(oway), '0);
        chk("rst_hit", LW'(ohit), '0);
        chk("rst_multi", LW'(omulti), '0);
        chk("rst_err", LW'(oerr), '0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            l = mk_lines(i + 1);
            e = mk_exp(l, tbl[i].way, tbl[i].hit, tbl[i].multi,
                       tbl[i].wm, tbl[i].off);
            send(l, tbl[i].sel, tbl[i].off, tbl[i].wm, e);
            #1;
            chk("latency_valid", LW'(vout), LW'(1));
            chk("err_count", LW'(oerr), LW'(exp_err));
        end
        idle();
        wait_drain();

        l = mk_lines(40);
        l[0][255:192] = 64'hDEAD_BEEF_0123_4567;
        e.data  = {448'b0, 64'hDEAD_BEEF_0123_4567};
        e.way   = 2'd0;
        e.hit   = 1'b1;
        e.multi = 1'b0;
        send(l, 4'b0001, 3'd3, 1'b1, e);
        idle();
        wait_drain();

        @(negedge clk);
        rdy_in = 1'b0;
        l  = mk_lines(20);
        b0 = mk_exp(l, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0);
        b1 = mk_exp(l, 2'd1, 1'b1, 1'b0, 1'b1, 3'd6);
        b2 = mk_exp(l, 2'd2, 1'b1, 1'b0, 1'b0, 3'd0);
        send(l, 4'b0001, 3'd0, 1'b0, b0);
        send(l, 4'b0010, 3'd6, 1'b1, b1);
        fork
            send(l, 4'b0100, 3'd0, 1'b0, b2);
            begin
                for (int c = 0; c < 2; c++) begin
                    @(negedge clk);
                    #1;
                    chk("bp_ready_low", LW'(rdy_out), '0);
                    chk("bp_valid", LW'(vout), LW'(1));
                    chk("bp_hold_data", odata, b0.data);
                    chk("bp_hold_way", LW'(oway), '0);
                end
                @(negedge clk);
                rdy_in = 1'b1;
            end
        join
        idle();
        wait_drain();

        l = mk_lines(30);
        e = mk_exp(l, 2'd1, 1'b1, 1'b1, 1'b0, 3'd0);
        while (exp_err != 16'hFFFF) send(l, 4'b0110, 3'd0, 1'b0, e);
        #1;
        chk("err_at_max", LW'(oerr), LW'(16'hFFFF));
        send(l, 4'b0110, 3'd0, 1'b0, e);
        #1;
        chk("err_saturate", LW'(oerr), LW'(16'hFFFF));
        idle();
        wait_drain();

        @(negedge clk);
        rdy_in = 1'b0;
        l  = mk_lines(50);
        b0 = mk_exp(l, 2'd3, 1'b1, 1'b0, 1'b0, 3'd0);
        send(l, 4'b1000, 3'd0, 1'b0, b0);
        send(l, 4'b1000, 3'd0, 1'b0, b0);
        idle();
        #1;
        chk("full_ready_low", LW'(rdy_out), '0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", LW'(vout), '0);
        chk("mid_rst_ready", LW'(rdy_out), LW'(1));
        chk("mid_rst_data", odata, '0);
        chk("mid_rst_err", LW'(oerr), '0);
        pushes -= sb.size();
        sb.delete();
        exp_err = 16'd0;
        #1 rst_n = 1'b1;
        @(negedge clk);
        rdy_in = 1'b1;
        l = mk_lines(60);
        e = mk_exp(l, 2'd2, 1'b1, 1'b0, 1'b1, 3'd4);
        send(l, 4'b0100, 3'd4, 1'b1, e);
        #1;
        chk("post_rst_valid", LW'(vout), LW'(1));
        chk("post_rst_err", LW'(oerr), '0);
        idle();
        wait_drain();

        chk("beat_count", LW'(pops), LW'(pushes));
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
